// File: rtl/data_mem_lsu.sv
// Sequential RV64 load/store unit in front of a simulated physical memory, with a fixed access latency.
// Optional misalignment trap is enabled by defining DATAMEM_MISALIGN_TRAP_EN.
module data_mem_lsu #(
  parameter int          ADDR_W     = 64,
  parameter int          LATENCY    = 1,
  parameter logic [63:0] IDLE_RADDR = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BASE   = 64'h0000_0000_8000_0000,
  parameter int          MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [2:0]        MemOP,
  input  logic              WrEn,
  input  logic [63:0]       DataIn,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       DataOut,
  output logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t       state, next_state;
  logic [3:0]   cnt;
  logic         accept, do_access;

  logic [63:0]  addr64;
  logic [63:0]  lat_addr, lat_data;
  logic [2:0]   lat_op;
  logic         lat_wr;

  logic [63:0]  acc_addr, acc_data;
  logic [2:0]   acc_op;
  logic         acc_wr;

  logic         reserved, fault, rd_en, wr_en;
  logic [2:0]   off, eff_off, lo_mask;
  logic [7:0]   byte_en, wmask;
  logic [63:0]  wdata, raw, shifted, load_val;
  logic [60:0]  rd_dw, wr_dw;
  logic         sx;

  logic [63:0]  data_out;
  logic         err_q;

  // Simulated physical memory: a window of 2**MEM_AW doublewords starting at MEM_BASE.
  logic [63:0]  mem [0:(1<<MEM_AW)-1];

  function automatic logic in_win(input logic [60:0] dw);
    return dw[60:MEM_AW] == MEM_BASE[63:MEM_AW+3];
  endfunction

  assign addr64 = 64'(Addr);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            do_access  = 1'b1;
            next_state = S_RESP;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          do_access  = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // With a single-cycle latency the access happens on the accept edge, straight from the request.
  always_comb begin
    acc_addr = lat_addr;
    acc_op   = lat_op;
    acc_wr   = lat_wr;
    acc_data = lat_data;
    if (LATENCY == 1) begin
      acc_addr = addr64;
      acc_op   = MemOP;
      acc_wr   = WrEn;
      acc_data = DataIn;
    end

    reserved = (acc_op == 3'b111) || (acc_wr && acc_op[2]);
    off      = acc_addr[2:0];
    case (acc_op[1:0])
      2'b00:   begin lo_mask = 3'b000; byte_en = 8'h01; end
      2'b01:   begin lo_mask = 3'b001; byte_en = 8'h03; end
      2'b10:   begin lo_mask = 3'b011; byte_en = 8'h0F; end
      default: begin lo_mask = 3'b111; byte_en = 8'hFF; end
    endcase

`ifdef DATAMEM_MISALIGN_TRAP_EN
    fault   = reserved || ((off & lo_mask) != 3'b000);
    eff_off = off;
`else
    fault   = reserved;
    eff_off = off & ~lo_mask;
`endif

    wmask = byte_en << eff_off;
    wdata = acc_data << {eff_off, 3'b000};
    wr_dw = acc_addr[63:3];
    wr_en = do_access && acc_wr && !fault && in_win(wr_dw);

    // Reads only ever see a latched, non-faulting address; otherwise the safe dummy.
    rd_en = do_access && !acc_wr && !fault;
    rd_dw = rd_en ? acc_addr[63:3] : IDLE_RADDR[63:3];
    raw   = in_win(rd_dw) ? mem[rd_dw[MEM_AW-1:0]] : 64'd0;

    shifted = raw >> {eff_off, 3'b000};
    sx      = ~acc_op[2];
    case (acc_op[1:0])
      2'b00:   load_val = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_op   <= '0;
      lat_wr   <= 1'b0;
      data_out <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr <= addr64;
        lat_data <= DataIn;
        lat_op   <= MemOP;
        lat_wr   <= WrEn;
        cnt      <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd1) begin
        cnt <= cnt - 4'd1;
      end

      if (do_access) begin
        cnt      <= '0;
        data_out <= (acc_wr || fault) ? 64'd0 : load_val;
        err_q    <= fault;
      end else if (resp_valid && resp_ready) begin
        data_out <= '0;
        err_q    <= 1'b0;
      end
    end
  end

  // NOTE: the memory array is deliberately not reset; reset only clears control state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask[b]) mem[wr_dw[MEM_AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign DataOut  = data_out;
  assign resp_err = err_q;

endmodule
